// File: rtl/photon_gate_counter.sv
// photon_gate_counter
//   Front end of the single-shot readout stage. Synchronises the raw APD
//   pulse train, optionally blanks events for a dead time after each counted
//   photon, and counts photons inside a sequencer-requested gate window.
//   The window is aborted early when the readout stage reports a decision.
//
//   Optional feature macro: PHOTON_DEADTIME_EN (dead-time filter compiled in).
//
// Parameters
//   CNT_W     width of the cumulative photon count and of gate_len
//   DEADTIME  blanking cycles after each counted photon (dead-time build only)
//   ARM_CYC   cycles start_rst is held high (2..15)
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous active-high reset
//   apd_in           raw photon pulse, asynchronous to clk
//   gate_start       one-cycle request to open a detection window
//   gate_len         window length in clk cycles (0 behaves as 1)
//   trig_done        readout decision, aborts an active count window
//   cnt_start        cumulative photon count since window arm (saturating)
//   start_rst        detection-start level, high during the arm phase
//   stop_singleshot  detection-end level, high for 2 cycles after the window
//   busy             high whenever the block is not idle
//   overflow         sticky: count reached full scale in the current window
module photon_gate_counter #(
  parameter int CNT_W    = 24,
  parameter int DEADTIME = 4,
  parameter int ARM_CYC  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             apd_in,
  input  logic             gate_start,
  input  logic [CNT_W-1:0] gate_len,
  input  logic             trig_done,
  output logic [CNT_W-1:0] cnt_start,
  output logic             start_rst,
  output logic             stop_singleshot,
  output logic             busy,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_COUNT,
    S_HOLD
  } state_t;

  localparam logic [3:0] ARM_LAST = 4'(ARM_CYC - 1);

  state_t           state;
  state_t           state_nxt;

  logic             sync0;
  logic             sync1;
  logic             sync2;
  logic             event_raw;
  logic             event_cnt;
  logic             count_en;

  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] win;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       arm_cnt;
  logic             hold_cnt;

  // Input synchroniser plus history stage; an event is a synchronised rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync0 <= apd_in;
      sync1 <= sync0;
      sync2 <= sync1;
    end
  end

  assign event_raw = sync1 & ~sync2;
  // Counting happens only in COUNT cycles that are not being aborted.
  assign count_en  = (state == S_COUNT) && !trig_done;
  assign cnt_inc   = cnt_start + 1'b1;

`ifdef PHOTON_DEADTIME_EN
  localparam int BLANK_W = (DEADTIME > 1) ? $clog2(DEADTIME + 1) : 1;
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(DEADTIME);

  logic [BLANK_W-1:0] blank;

  assign event_cnt = event_raw && (blank == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank <= '0;
    end else if (state == S_IDLE && gate_start) begin
      blank <= '0;
    end else if (count_en && event_cnt) begin
      blank <= BLANK_LOAD;
    end else if (blank != '0) begin
      blank <= blank - 1'b1;
    end
  end
`else
  logic unused_deadtime;

  assign event_cnt       = event_raw;
  assign unused_deadtime = (DEADTIME != 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    start_rst       = 1'b0;
    stop_singleshot = 1'b0;
    busy            = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (gate_start) begin
          state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        start_rst = 1'b1;
        if (arm_cnt == ARM_LAST) begin
          state_nxt = S_COUNT;
        end
      end
      S_COUNT: begin
        // Abort outranks window expiry, so a coincident decision skips HOLD.
        if (trig_done) begin
          state_nxt = S_IDLE;
        end else if (win == len_q - 1'b1) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        stop_singleshot = 1'b1;
        if (hold_cnt) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        busy      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      win       <= '0;
      arm_cnt   <= '0;
      hold_cnt  <= 1'b0;
      cnt_start <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gate_start) begin
            len_q     <= (gate_len == '0) ? CNT_W'(1) : gate_len;
            cnt_start <= '0;
            overflow  <= 1'b0;
            arm_cnt   <= '0;
          end
        end
        S_ARM: begin
          arm_cnt <= arm_cnt + 1'b1;
          win     <= '0;
        end
        S_COUNT: begin
          hold_cnt <= 1'b0;
          if (count_en) begin
            win <= win + 1'b1;
            if (event_cnt) begin
              if (cnt_start != '1) begin
                cnt_start <= cnt_inc;
              end
              // Flag as soon as full scale is reached: further photons cannot be represented.
              if (cnt_start == '1 || cnt_inc == '1) begin
                overflow <= 1'b1;
              end
            end
          end
        end
        S_HOLD: begin
          hold_cnt <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
